// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage and its neighbours: fetch FSM
// state encoding, the canonical NOP, base opcodes and instruction field positions.
package riscv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } fetch_state_t;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_I   = 7'b0010011;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC selection: sequential pc+4 (modulo 2^XLEN) or the branch/jump
// target with its two low bits cleared so fetches stay word aligned.
module pc_next_logic #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_target,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc
);

  logic [XLEN-1:0] w_aligned_target;

  assign o_pc_plus4       = i_pc + XLEN'(4);
  assign w_aligned_target = i_target & {{(XLEN-2){1'b1}}, 2'b00};
  assign o_next_pc        = i_redirect ? w_aligned_target : o_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, holds the returned
// instruction for decode. Optional retired-fetch counter under FETCH_PERF_CNT_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are
// both high; a valid source keeps its payload stable until that edge.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [6:0]      op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_target,
  output logic [1:0]      dbg_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     fetch_count
`endif
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_instr_valid;
  logic [XLEN-1:0] w_next_pc;
  logic [XLEN-1:0] w_pc_plus4;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     r_fetch_count;
`endif

  pc_next_logic #(.XLEN(XLEN)) u_pc_next (
    .i_pc       (r_pc),
    .i_redirect (redirect),
    .i_target   (redirect_target),
    .o_pc_plus4 (w_pc_plus4),
    .o_next_pc  (w_next_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_REQ;
      r_fetch_pc    <= RESET_PC;
      r_pc          <= RESET_PC;
      r_instr       <= NOP_INSTR;
      r_instr_valid <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
      r_fetch_count <= '0;
`endif
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_req_ready) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            r_instr       <= imem_rsp_data;
            r_pc          <= r_fetch_pc;
            r_instr_valid <= 1'b1;
            r_state       <= S_HOLD;
          end
        end
        S_HOLD: begin
          // redirect is only meaningful in the cycle decode consumes
          if (instr_ready) begin
            r_fetch_pc    <= w_next_pc;
            r_instr       <= NOP_INSTR;
            r_instr_valid <= 1'b0;
            r_state       <= S_REQ;
`ifdef FETCH_PERF_CNT_EN
            r_fetch_count <= r_fetch_count + 32'd1;
`endif
          end
        end
        default: r_state <= S_REQ;
      endcase
    end
  end

  // Gated by reset so no request can be accepted in the reset cycle itself.
  assign imem_req_valid = (r_state == S_REQ) && !reset;
  assign imem_addr      = r_fetch_pc;
  assign instr_valid    = r_instr_valid;
  assign instr          = r_instr;
  assign op             = r_instr[OP_MSB:OP_LSB];
  assign funct3         = r_instr[F3_MSB:F3_LSB];
  assign funct7         = r_instr[F7_MSB:F7_LSB];
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;
  assign dbg_state      = r_state;
`ifdef FETCH_PERF_CNT_EN
  assign fetch_count    = r_fetch_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a reactive instruction-memory model
// plus an expected-address scoreboard; exercises FETCH_PERF_CNT_EN when defined.
module tb_fetch_unit;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .op              (op),
    .funct3          (funct3),
    .funct7          (funct7),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .dbg_state       (dbg_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count     (fetch_count)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  logic [31:0] exp_q[$];
  int          checks = 0;
  int          passed = 0;
  logic        stray_rsp = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'h0020_8463;
    return 32'h0050_0093 ^ {a[21:0], 10'b0};
  endfunction

  // One clock: sample handshake on the falling edge, then drive the memory
  // response just after the rising edge.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    logic [31:0] e;
    @(negedge clk);
    acc = imem_req_valid && imem_req_ready;
    a   = imem_addr;
    if (acc) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_req addr=%h expected none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) $display("FAIL req_addr got=%h exp=%h", a, e);
        else passed++;
      end
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    if (acc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(a);
    end else if (stray_rsp) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'hDEAD_0000 | $urandom_range(0, 16'hFFFF);
    end
  endtask

  task automatic consume(input logic redir, input logic [31:0] tgt);
    instr_ready     = 1'b1;
    redirect        = redir;
    redirect_target = tgt;
    tick();
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = $urandom;
  endtask

  task automatic fetch_and_check(input logic [31:0] ea, input int exp_lat);
    logic [31:0] ew;
    int n;
    exp_q.push_back(ea);
    ew = mem_word(ea);
    n  = 0;
    while (!instr_valid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (instr_valid !== 1'b1) $display("FAIL instr_valid_timeout addr=%h got=%b exp=1", ea, instr_valid);
    else passed++;
    if (exp_lat > 0) begin
      checks++;
      if (n != exp_lat) $display("FAIL latency addr=%h got=%0d exp=%0d", ea, n, exp_lat);
      else passed++;
    end
    checks++;
    if (instr !== ew) $display("FAIL instr addr=%h got=%h exp=%h", ea, instr, ew);
    else passed++;
    checks++;
    if (pc !== ea) $display("FAIL pc got=%h exp=%h", pc, ea);
    else passed++;
    checks++;
    if (pc_plus4 !== ea + 32'd4) $display("FAIL pc_plus4 got=%h exp=%h", pc_plus4, ea + 32'd4);
    else passed++;
    checks++;
    if ({op, funct3, funct7} !== {ew[6:0], ew[14:12], ew[31:25]})
      $display("FAIL fields got=%h/%h/%h exp=%h/%h/%h", op, funct3, funct7, ew[6:0], ew[14:12], ew[31:25]);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0)
      $display("FAIL reset_cycle_valids got=%b%b exp=00", imem_req_valid, instr_valid);
    else passed++;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (instr !== 32'h0000_0013 || op !== 7'h13 || funct3 !== 3'd0 || funct7 !== 7'd0)
      $display("FAIL reset_instr got=%h exp=00000013", instr);
    else passed++;
    checks++;
    if (pc !== 32'h0 || pc_plus4 !== 32'h4) $display("FAIL reset_pc got=%h/%h exp=0/4", pc, pc_plus4);
    else passed++;
    checks++;
    if (instr_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h0 || dbg_state !== S_REQ)
      $display("FAIL reset_req got=%b%b addr=%h st=%0d exp=01 addr=0 st=0",
               instr_valid, imem_req_valid, imem_addr, dbg_state);
    else passed++;
  endtask

  task automatic test_first_fetch();
    fetch_and_check(32'h0, 2);
    checks++;
    if (op !== 7'h13 || funct3 !== 3'd0) $display("FAIL first_fields got=%h/%h exp=13/0", op, funct3);
    else passed++;
  endtask

  task automatic test_sequential();
    consume(1'b0, 32'h0000_0100);
    fetch_and_check(32'h4, 2);
    consume(1'b0, 32'h0000_0200);
    fetch_and_check(32'h8, 2);
    checks++;
    if (op !== OP_BEQ) $display("FAIL beq_op got=%h exp=%h", op, OP_BEQ);
    else passed++;
  endtask

  task automatic test_branch();
    consume(1'b1, 32'h40);
    fetch_and_check(32'h40, 2);
    consume(1'b1, 32'h43);
    fetch_and_check(32'h40, 2);
  endtask

  task automatic test_back_pressure();
    int bad;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        redirect        = 1'b1;
        redirect_target = 32'h100;
      end
      tick();
      redirect = 1'b0;
      if (instr_valid !== 1'b1 || instr !== mem_word(32'h40) || pc !== 32'h40 || imem_req_valid !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL hold_stable got=%0d unstable cycles exp=0", bad);
    else passed++;
    consume(1'b0, 32'h0);
  endtask

  task automatic test_req_stall();
    int bad;
    bad = 0;
    imem_req_ready = 1'b0;
    stray_rsp      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44 || instr_valid !== 1'b0 || instr !== 32'h13)
        bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL req_stall got=%0d bad cycles exp=0", bad);
    else passed++;
    imem_req_ready = 1'b1;
    stray_rsp      = 1'b0;
    fetch_and_check(32'h44, -1);
    consume(1'b0, 32'h0);
  endtask

  task automatic test_reset_in_wait();
    exp_q.push_back(32'h48);
    tick();
    checks++;
    if (dbg_state !== S_WAIT) $display("FAIL wait_state got=%0d exp=%0d", dbg_state, S_WAIT);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h13 || pc !== 32'h0)
      $display("FAIL reset_in_wait got=%b/%h/%h exp=0/00000013/0", instr_valid, instr, pc);
    else passed++;
    fetch_and_check(32'h0, 2);
  endtask

  task automatic test_wrap();
    consume(1'b1, 32'hFFFF_FFFE);
    fetch_and_check(32'hFFFF_FFFC, 2);
    consume(1'b0, 32'h40);
    fetch_and_check(32'h0, 2);
    consume(1'b0, 32'h40);
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_count();
    reset = 1'b1;
    tick();
    exp_q.delete();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      fetch_and_check(32'(i * 4), 2);
      consume(1'b0, 32'h0);
    end
    checks++;
    if (fetch_count !== 32'd3) $display("FAIL fetch_count got=%0d exp=3", fetch_count);
    else passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    checks++;
    if (fetch_count !== 32'd0) $display("FAIL fetch_count_reset got=%0d exp=0", fetch_count);
    else passed++;
  endtask
`endif

  initial begin
    reset           = 1'b1;
    imem_req_ready  = 1'b1;
    imem_rsp_valid  = 1'b0;
    imem_rsp_data   = 32'h0;
    instr_ready     = 1'b0;
    redirect        = 1'b0;
    redirect_target = 32'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_first_fetch();
    test_sequential();
    test_branch();
    test_back_pressure();
    test_req_stall();
    test_reset_in_wait();
    test_wrap();
`ifdef FETCH_PERF_CNT_EN
    test_perf_count();
`endif
    checks++;
    if (exp_q.size() != 0) $display("FAIL missing_reqs got=%0d outstanding exp=0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
